// File: rtl/lor_err_monitor.sv
// Error-statistics monitor for lower-part-OR approximate adders.
// Each accepted sample is compared with the exact sum and folded into
// windowed statistics: error count, saturating error-distance sum and
// maximum error. The host reads the results once done is high.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for the first start after reset
// S_RUN   | accepting samples until sample_count reaches win_len
// S_DRAIN | no new samples; waiting for the pipeline stage to retire
// S_DONE  | statistics final and held until the next start or rst
module lor_err_monitor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] win_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH:0]   in_approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] err_sum,
    output logic [WIDTH:0]   err_max
);

    // Wide enough to hold err_sum plus one diff without losing the carry,
    // even when the accumulator is narrower than a single diff.
    localparam int EXT_W = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] win_len_q, win_len_d;
    logic [CNT_W-1:0] sample_count_q, sample_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [ACC_W-1:0] err_sum_q, err_sum_d;
    logic [WIDTH:0]   err_max_q, err_max_d;
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH:0]   s1_diff_q, s1_diff_d;
    logic             s1_flag_q, s1_flag_d;

    logic [WIDTH:0]   exact;
    logic [WIDTH:0]   abs_diff;
    logic [EXT_W-1:0] sum_ext;
    logic             xfer;

    // Exact reference sum and absolute error distance of the offered sample.
    always_comb begin
        exact    = {1'b0, in_a} + {1'b0, in_b};
        abs_diff = (in_approx >= exact) ? (in_approx - exact) : (exact - in_approx);
        sum_ext  = EXT_W'(err_sum_q) + EXT_W'(s1_diff_q);
    end

    // Handshake and status come from registered state only.
    always_comb begin
        in_ready = (state_q == S_RUN) && (sample_count_q < win_len_q);
        xfer     = in_valid && in_ready;
        busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
        done     = (state_q == S_DONE);
    end

    // Next-state, sample acceptance, stage-1 capture and stage-2 statistics.
    always_comb begin
        state_d        = state_q;
        win_len_d      = win_len_q;
        sample_count_d = sample_count_q;
        err_count_d    = err_count_q;
        err_sum_d      = err_sum_q;
        err_max_d      = err_max_q;
        s1_valid_d     = 1'b0;
        s1_diff_d      = s1_diff_q;
        s1_flag_d      = s1_flag_q;

        if (s1_valid_q) begin
            if (s1_flag_q) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
            if (sum_ext > EXT_W'({ACC_W{1'b1}})) begin
                err_sum_d = '1;
            end else begin
                err_sum_d = ACC_W'(sum_ext);
            end
            if (s1_diff_q > err_max_q) begin
                err_max_d = s1_diff_q;
            end
        end

        case (state_q)
            S_RUN: begin
                if (xfer) begin
                    sample_count_d = sample_count_q + CNT_W'(1);
                    s1_valid_d     = 1'b1;
                    s1_diff_d      = abs_diff;
                    s1_flag_d      = (abs_diff != '0);
                    if (sample_count_d == win_len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!s1_valid_q) begin
                    state_d = S_DONE;
                end
            end
            default: ;
        endcase

        // A new window wins over everything, including a same-cycle transfer.
        if (start) begin
            win_len_d      = win_len;
            sample_count_d = '0;
            err_count_d    = '0;
            err_sum_d      = '0;
            err_max_d      = '0;
            s1_valid_d     = 1'b0;
            state_d        = (win_len == '0) ? S_DRAIN : S_RUN;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            win_len_q      <= '0;
            sample_count_q <= '0;
            err_count_q    <= '0;
            err_sum_q      <= '0;
            err_max_q      <= '0;
            s1_valid_q     <= 1'b0;
            s1_diff_q      <= '0;
            s1_flag_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            win_len_q      <= win_len_d;
            sample_count_q <= sample_count_d;
            err_count_q    <= err_count_d;
            err_sum_q      <= err_sum_d;
            err_max_q      <= err_max_d;
            s1_valid_q     <= s1_valid_d;
            s1_diff_q      <= s1_diff_d;
            s1_flag_q      <= s1_flag_d;
        end
    end

    assign sample_count = sample_count_q;
    assign err_count    = err_count_q;
    assign err_sum      = err_sum_q;
    assign err_max      = err_max_q;

endmodule

// File: doc/lor_err_monitor.md
Name: lor_err_monitor

Overview:
- Consumer-side checker for lower-part-OR (LOR) approximate adders.
- Accepts operand pairs with the approximate sum produced by the adder under test, computes the exact sum internally, and accumulates error statistics over a programmable window: erroneous-sample count, sum of absolute error distance, and maximum error.
- Sits after the approximate adder datapath in characterisation and test harnesses; results are read by the host once done is asserted.

Parameters:
- WIDTH, 8, operand width; sums are WIDTH+1 bits.
- CNT_W, 16, width of the window length and sample/error counters.
- ACC_W, 32, width of the error-distance accumulator.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; clears statistics, latches win_len, begins a window.
- win_len  input  CNT_W  number of samples in the window; sampled only on start.
- in_valid  input  1  sample present on in_a/in_b/in_approx.
- in_ready  output  1  monitor accepts a sample this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_approx  input  WIDTH+1  approximate sum from the adder under test.
- busy  output  1  window in progress (RUN or DRAIN).
- done  output  1  statistics final; held until the next start or rst.
- sample_count  output  CNT_W  samples accepted in the current window.
- err_count  output  CNT_W  samples with in_approx not equal to the exact sum.
- err_sum  output  ACC_W  sum of |in_approx - (in_a+in_b)|, saturating.
- err_max  output  WIDTH+1  largest single absolute error.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst). On rst, all outputs are 0, the FSM goes to IDLE, and the pipeline valids are cleared. Reset mid-window discards all partial results.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: wait for start.
  - start in any state clears the counters, accumulator, err_max, done and pipeline valids, and latches win_len.
    - If win_len is 0, the next state is DRAIN.
    - Otherwise the next state is RUN.
  - RUN: in_ready = 1 while sample_count < win_len. A sample transfers when in_valid && in_ready. When the transfer brings sample_count to win_len, the next state is DRAIN and in_ready drops in the following cycle.
  - DRAIN: in_ready = 0. Stay here until both pipeline stages are empty, then go to DONE.
  - DONE: done = 1 and all statistics are stable. Remain here until start or rst.
  - start has priority over a sample transfer in the same cycle; that sample is dropped and not counted.
- Pipeline (2 stages; statistics update 2 cycles after transfer):
  - Stage 1 registers exact = in_a + in_b (WIDTH+1 bits, zero-extended), the absolute difference |in_approx - exact| (WIDTH+1 bits, always non-negative), and an error flag (diff != 0).
  - Stage 2 updates the statistics:
    - err_count += flag.
    - err_sum += diff, saturating at 2^ACC_W - 1.
    - err_max = max(err_max, diff).
  - sample_count increments at the transfer itself, not after the pipeline.
- Counters: err_count never exceeds sample_count. Neither counter wraps because both are bounded by win_len.
- in_ready is registered-state based only and has no combinational dependence on in_valid. in_valid low in RUN simply stalls; there is no timeout.
- Inputs presented while in_ready = 0 are ignored.
- busy = 1 in RUN and DRAIN; done and busy are never 1 together.

Test Plan:
- WIDTH=8, win_len=3, back-to-back samples:
  - (0x05,0x0A,approx 0x00F) gives error 0.
  - (0x0F,0x01,approx 0x00F) gives error 1.
  - (0xFF,0xFF,approx 0x1EF) gives error 15.
  - Expect done=1 with sample_count=3, err_count=2, err_sum=16, err_max=15.
- win_len=4 with in_valid toggling every other cycle → exactly 4 samples accepted, in_ready=0 from the cycle after the 4th transfer, done 2–3 cycles later, no extra counts.
- win_len=0 → done asserted within 3 cycles of start, all statistics 0, in_ready never 1.
- ACC_W=8, 20 samples each with error 15 → err_sum saturates at 255, err_count=20, err_max=15.
- Mid-window events:
  - start after 2 of 5 samples → statistics cleared, a fresh 5-sample window completes.
  - rst after 2 samples → all outputs 0, FSM idle until the next start.
- start asserted in the same cycle as an in_valid && in_ready transfer → that sample is not counted, and sample_count=0 the next cycle.
